// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the MULDIV output stage.
//   - DEFAULT_XLEN : operand/result width (only 32 is supported)
//   - OP_*         : RV32M funct3 codes as seen on the op port
//   - is_div()     : true for the divide/remainder half of the opcode space
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // funct3[2] splits the multiply group from the divide group.
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_restore_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
//   Conditional two's-complement negation of a W-bit magnitude.
//   Ports:
//     data_i  in  W   unsigned magnitude
//     neg_i   in  1   negate when high
//     data_o  out W   neg_i ? -data_i (mod 2^W) : data_i
//   Negating 0 gives 0 and negating the most negative value gives itself;
//   both fall out of the modular arithmetic with no special casing.
// ---------------------------------------------------------------------------
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/muldiv_sign_restore.sv
// ---------------------------------------------------------------------------
// muldiv_sign_restore
//   Output stage of the MULDIV unit. Takes the unsigned magnitude result of
//   the iterative multiplier/divider, re-applies the operand signs, selects
//   the 32-bit RV32M result and applies the divide-by-zero and signed
//   overflow rules. Two register stages with a valid/ready handshake on each
//   side; one result per cycle, strictly in order.
//   Ports:
//     clk        in   1        rising-edge clock
//     rstn       in   1        synchronous active-low reset
//     in_valid   in   1        upstream result valid
//     in_ready   out  1        stage 1 can accept (combinational)
//     op         in   3        RV32M funct3
//     sign_a     in   1        bit 31 of the original rs1
//     sign_b     in   1        bit 31 of the original rs2
//     a_orig     in   XLEN     original rs1 (REM/REMU divide-by-zero result)
//     div_zero   in   1        divisor was zero (divide ops only)
//     div_ovf    in   1        signed 0x80000000 / -1 (DIV/REM only)
//     in_data    in   2*XLEN   MUL: |a|*|b| product; DIV: {rem, quot}
//     out_valid  out  1        result valid
//     out_ready  in   1        downstream accepts
//     result     out  XLEN     sign-corrected result
// ---------------------------------------------------------------------------
module muldiv_sign_restore
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [XLEN-1:0]   a_orig,
  input  logic              div_zero,
  input  logic              div_ovf,
  input  logic [2*XLEN-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result
);

  // Stage 1 registers
  logic              s1Valid_q,   s1Valid_d;
  logic [2:0]        s1Op_q,      s1Op_d;
  logic              s1Neg_q,     s1Neg_d;
  logic              s1DivZero_q, s1DivZero_d;
  logic              s1DivOvf_q,  s1DivOvf_d;
  logic [XLEN-1:0]   s1AOrig_q,   s1AOrig_d;
  logic [2*XLEN-1:0] s1Data_q,    s1Data_d;

  // Output stage registers
  logic              outValid_q,  outValid_d;
  logic [XLEN-1:0]   result_q,    result_d;

  logic              inAccept;
  logic              s1Advance;
  logic              negIn;
  logic              divZeroIn;
  logic              divOvfIn;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quotSigned;
  logic [XLEN-1:0]   remSigned;
  logic [XLEN-1:0]   stage2Result;

  // Stage 1 may take a new entry when it is empty or when its current
  // entry is leaving this same cycle (output empty or being drained).
  assign in_ready  = !s1Valid_q || !outValid_q || out_ready;
  assign inAccept  = in_valid && in_ready;
  assign s1Advance = s1Valid_q && (!outValid_q || out_ready);

  // Which operands were signed decides whether the magnitude result needs
  // negating. REM takes the dividend's sign; MULHSU only has a signed rs1.
  always_comb begin
    negIn = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV:   negIn = sign_a ^ sign_b;
      OP_MULHSU, OP_REM:         negIn = sign_a;
      OP_MULHU, OP_DIVU, OP_REMU: negIn = 1'b0;
      default:                   negIn = 1'b0;
    endcase
  end

  // Special cases are qualified here so stage 2 never has to look at the
  // opcode class again: divide-by-zero only matters for divide ops, and the
  // signed overflow only for the signed divide ops.
  assign divZeroIn = is_div(op) && div_zero;
  assign divOvfIn  = ((op == OP_DIV) || (op == OP_REM)) && div_ovf;

  // Stage 1 next state: load on accept, otherwise empty out when the entry
  // moves on to the output stage, otherwise hold.
  always_comb begin
    s1Valid_d   = s1Valid_q;
    s1Op_d      = s1Op_q;
    s1Neg_d     = s1Neg_q;
    s1DivZero_d = s1DivZero_q;
    s1DivOvf_d  = s1DivOvf_q;
    s1AOrig_d   = s1AOrig_q;
    s1Data_d    = s1Data_q;
    if (inAccept) begin
      s1Valid_d   = 1'b1;
      s1Op_d      = op;
      s1Neg_d     = negIn;
      s1DivZero_d = divZeroIn;
      s1DivOvf_d  = divOvfIn;
      s1AOrig_d   = a_orig;
      s1Data_d    = in_data;
    end else if (s1Advance) begin
      s1Valid_d   = 1'b0;
    end
  end

  // One wide negator for the full product (the high word depends on the
  // borrow out of the low word), two narrow ones for quotient and remainder.
  cond_negate #(.W(2*XLEN)) u_prodNeg (
    .data_i (s1Data_q),
    .neg_i  (s1Neg_q),
    .data_o (prodSigned)
  );

  cond_negate #(.W(XLEN)) u_quotNeg (
    .data_i (s1Data_q[XLEN-1:0]),
    .neg_i  (s1Neg_q),
    .data_o (quotSigned)
  );

  cond_negate #(.W(XLEN)) u_remNeg (
    .data_i (s1Data_q[2*XLEN-1:XLEN]),
    .neg_i  (s1Neg_q),
    .data_o (remSigned)
  );

  // Result selection. funct3[1] picks remainder over quotient within the
  // divide group. Divide-by-zero outranks overflow.
  always_comb begin
    stage2Result = '0;
    if (!is_div(s1Op_q)) begin
      if (s1Op_q == OP_MUL) begin
        stage2Result = prodSigned[XLEN-1:0];
      end else begin
        stage2Result = prodSigned[2*XLEN-1:XLEN];
      end
    end else if (s1DivZero_q) begin
      stage2Result = s1Op_q[1] ? s1AOrig_q : '1;
    end else if (s1DivOvf_q) begin
      stage2Result = s1Op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      stage2Result = s1Op_q[1] ? remSigned : quotSigned;
    end
  end

  // Output stage next state: capture when stage 1 advances, drop valid once
  // the consumer takes the result, and otherwise hold result and valid.
  always_comb begin
    outValid_d = outValid_q;
    result_d   = result_q;
    if (s1Advance) begin
      outValid_d = 1'b1;
      result_d   = stage2Result;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // All state clears on reset, so anything in flight is simply discarded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1Valid_q   <= 1'b0;
      s1Op_q      <= '0;
      s1Neg_q     <= 1'b0;
      s1DivZero_q <= 1'b0;
      s1DivOvf_q  <= 1'b0;
      s1AOrig_q   <= '0;
      s1Data_q    <= '0;
      outValid_q  <= 1'b0;
      result_q    <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Op_q      <= s1Op_d;
      s1Neg_q     <= s1Neg_d;
      s1DivZero_q <= s1DivZero_d;
      s1DivOvf_q  <= s1DivOvf_d;
      s1AOrig_q   <= s1AOrig_d;
      s1Data_q    <= s1Data_d;
      outValid_q  <= outValid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = outValid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_sign_restore.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sign_restore
//   Self-checking bench for muldiv_sign_restore. Directed cases first, then
//   randomized operands. Expected results come from a reference model that
//   works on the original signed/unsigned operands with plain arithmetic;
//   the bench builds the magnitude inputs itself the way the upstream
//   datapath would. A queue holds expected results in acceptance order.
// ---------------------------------------------------------------------------
module tb_muldiv_sign_restore;
  import muldiv_pkg::*;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_orig;
  logic        div_zero;
  logic        div_ovf;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int          total;
  int          bad;
  logic [31:0] expQ[$];
  logic [31:0] curExp;
  logic        prevStall;
  logic [31:0] prevResult;

  logic [31:0] rndA;
  logic [31:0] rndB;
  logic [2:0]  rndOp;
  logic [63:0] rndData;
  logic        rndZero;
  logic        rndOvf;

  muldiv_sign_restore #(.XLEN(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .a_orig    (a_orig),
    .div_zero  (div_zero),
    .div_ovf   (div_ovf),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural RV32M result computed from the original operands.
  function automatic logic [31:0] refModel(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // What the upstream magnitude datapath would hand over for these operands.
  task automatic makeMagnitude(input  logic [2:0]  f,
                               input  logic [31:0] a,
                               input  logic [31:0] b,
                               output logic [63:0] data,
                               output logic        dz,
                               output logic        dov);
    logic        signedA;
    logic        signedB;
    logic [31:0] absA;
    logic [31:0] absB;
    signedA = (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
              (f == OP_DIV) || (f == OP_REM);
    signedB = (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    absA = (signedA && a[31]) ? (32'd0 - a) : a;
    absB = (signedB && b[31]) ? (32'd0 - b) : b;
    if (!f[2]) begin
      data = {32'b0, absA} * {32'b0, absB};
      dz   = 1'($urandom_range(0, 1));
      dov  = 1'($urandom_range(0, 1));
    end else begin
      dz  = (b == 32'd0);
      dov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) data = {$urandom, $urandom};
      else            data = {absA % absB, absA / absB};
    end
  endtask

  task automatic checkOutput(input string tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0]  f,
                               input logic        sa,
                               input logic        sb,
                               input logic [31:0] aOrig,
                               input logic        dz,
                               input logic        dov,
                               input logic [63:0] data,
                               input logic [31:0] expected);
    in_valid = 1'b1;
    op       = f;
    sign_a   = sa;
    sign_b   = sb;
    a_orig   = aOrig;
    div_zero = dz;
    div_ovf  = dov;
    in_data  = data;
    curExp   = expected;
  endtask

  // Called just after a falling edge with inputs driven; scores this cycle's
  // handshakes, then advances to the next falling edge.
  task automatic tick();
    logic [31:0] expected;
    #1;
    if (prevStall) begin
      checkOutput("hold valid", 32'(out_valid), 32'd1);
      checkOutput("hold result", result, prevResult);
    end
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious output", 32'(out_valid), 32'd0);
      end else begin
        expected = expQ.pop_front();
        checkOutput("result", result, expected);
      end
    end
    if (in_valid && in_ready) expQ.push_back(curExp);
    prevStall  = out_valid && !out_ready;
    prevResult = result;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 8 && expQ.size() != 0; n++) tick();
    checkOutput("drain empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runOne(input logic [2:0]  f,
                        input logic        sa,
                        input logic        sb,
                        input logic [31:0] aOrig,
                        input logic        dz,
                        input logic        dov,
                        input logic [63:0] data,
                        input logic [31:0] expected);
    out_ready = 1'b1;
    applyStimulus(f, sa, sb, aOrig, dz, dov, data, expected);
    tick();
    drain();
  endtask

  task automatic resetDut();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn      = 1'b1;
    expQ.delete();
    prevStall = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; sign_a = 1'b0; sign_b = 1'b0; a_orig = '0;
    div_zero = 1'b0; div_ovf = 1'b0; in_data = '0;
    curExp = '0; prevStall = 1'b0; prevResult = '0;
    rndA = '0; rndB = '0; rndOp = '0; rndData = '0; rndZero = 1'b0; rndOvf = 1'b0;

    @(negedge clk);
    resetDut();
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    // Two-cycle latency on an empty pipe.
    out_ready = 1'b1;
    applyStimulus(OP_MUL, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd15, 32'hFFFF_FFF1);
    tick();
    in_valid = 1'b0;
    checkOutput("latency cycle1 out_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("latency cycle2 out_valid", 32'(out_valid), 32'd1);
    tick();
    drain();

    // Directed sign handling and special cases.
    runOne(OP_MULH,   1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'd6, 32'hFFFF_FFFF);
    runOne(OP_MULHU,  1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'd6, 32'h0000_0000);
    runOne(OP_MULHSU, 1'b1, 1'b1, 32'd0,     1'b0, 1'b0, 64'd6, 32'hFFFF_FFFF);
    runOne(OP_DIV,    1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'h0000_0001_0000_0003, 32'hFFFF_FFFD);
    runOne(OP_REM,    1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'h0000_0001_0000_0003, 32'hFFFF_FFFF);
    runOne(OP_DIV,    1'b1, 1'b0, 32'h123,   1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'hFFFF_FFFF);
    runOne(OP_DIVU,   1'b1, 1'b0, 32'h123,   1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'hFFFF_FFFF);
    runOne(OP_REM,    1'b1, 1'b0, 32'h123,   1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'h0000_0123);
    runOne(OP_REMU,   1'b1, 1'b0, 32'h123,   1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'h0000_0123);
    runOne(OP_DIV,    1'b1, 1'b1, 32'h123,   1'b1, 1'b1, 64'h0000_0007_0000_0003, 32'hFFFF_FFFF);
    runOne(OP_DIV,    1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 64'h0000_0007_0000_0003, 32'h8000_0000);
    runOne(OP_REM,    1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 64'h0000_0007_0000_0003, 32'h0000_0000);
    runOne(OP_DIVU,   1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 64'h0000_0007_0000_0003, 32'h0000_0003);
    runOne(OP_MUL,    1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 64'd15, 32'h0000_000F);
    runOne(OP_MUL,    1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'd0,  32'h0000_0000);
    runOne(OP_DIV,    1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 64'h0000_0000_8000_0000, 32'h8000_0000);

    // Backpressure: three back-to-back inputs against a stalled consumer.
    out_ready = 1'b0;
    applyStimulus(OP_MUL, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd11, 32'd11);
    #1 checkOutput("bp in_ready first", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(OP_MUL, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 64'd22, 32'd22);
    #1 checkOutput("bp in_ready second", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(OP_MULHU, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'h0000_0033_0000_0000, 32'h33);
    #1 checkOutput("bp in_ready full", 32'(in_ready), 32'd0);
    tick();
    tick();
    checkOutput("bp in_ready still full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    drain();

    // Reset while stalled with a full pipe drops everything.
    out_ready = 1'b0;
    applyStimulus(OP_MUL, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd44, 32'd44);
    tick();
    applyStimulus(OP_MUL, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd55, 32'd55);
    tick();
    in_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    checkOutput("stall reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("stall reset in_ready", 32'(in_ready), 32'd1);
    rstn      = 1'b1;
    expQ.delete();
    prevStall = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Randomized operands with random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       rndA = 32'h8000_0000;
        1:       rndA = $urandom_range(0, 20);
        default: rndA = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rndB = 32'd0;
        1:       rndB = 32'hFFFF_FFFF;
        2:       rndB = $urandom_range(1, 20);
        default: rndB = $urandom;
      endcase
      rndOp = 3'($urandom_range(0, 7));
      makeMagnitude(rndOp, rndA, rndB, rndData, rndZero, rndOvf);
      if ($urandom_range(0, 3) != 0)
        applyStimulus(rndOp, rndA[31], rndB[31], rndA, rndZero, rndOvf, rndData,
                      refModel(rndOp, rndA, rndB));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
